matrix_cfg_loader: RTL and testbench

Serial configuration writer for the 5x4 switch-matrix tile. It receives a framed serial bitstream and assembles the 18 six-bit routing-select words (top[0..4], bottom[0..4], left[0..3], right[0..3]) into a shadow register. It checks every field and a trailing even-parity bit. Only a fully validated frame is committed atomically to the flat configuration bus that drives the matrix select registers.

---
 rtl/matrix_cfg_pkg.sv | 47 ++++
 rtl/matrix_cfg_word_check.sv | 26 ++
 rtl/matrix_cfg_loader.sv | 132 +++++++++++++
 tb/tb_matrix_cfg_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_cfg_pkg.sv
// Shared constants, side-select codes and FSM states for the switch-matrix
// configuration loader.
package matrix_cfg_pkg;

   localparam int unsigned NTB    = 5;
   localparam int unsigned NLR    = 4;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned WORD_W = SEL_W + IDX_W;
   localparam int unsigned NWORDS = 2 * NTB + 2 * NLR;
   localparam int unsigned CFG_W  = NWORDS * WORD_W;

   localparam int unsigned BIT_W  = $clog2(WORD_W);
   localparam int unsigned WCNT_W = $clog2(NWORDS);
   localparam int unsigned POS_W  = $clog2(CFG_W);

   localparam int unsigned TOP_BASE    = 0;
   localparam int unsigned BOTTOM_BASE = TOP_BASE + NTB;
   localparam int unsigned LEFT_BASE   = BOTTOM_BASE + NTB;
   localparam int unsigned RIGHT_BASE  = LEFT_BASE + NLR;

   typedef enum logic [SEL_W-1:0] {
      SIDE_NONE   = 3'd0,
      SIDE_TOP    = 3'd1,
      SIDE_RIGHT  = 3'd2,
      SIDE_BOTTOM = 3'd3,
      SIDE_LEFT   = 3'd4
   } side_e;

   // Error code is {parity_fail, field_err}
   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_FIELD  = 2'b01;
   localparam logic [1:0] ERR_PARITY = 2'b10;
   localparam logic [1:0] ERR_BOTH   = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StParity
   } state_e;

   function automatic logic [POS_W-1:0] bit_pos(input logic [WCNT_W-1:0] word_idx,
                                                input logic [BIT_W-1:0]  bit_idx);
      return POS_W'(word_idx) * POS_W'(WORD_W) + POS_W'(bit_idx);
   endfunction

endpackage

// File: rtl/matrix_cfg_word_check.sv
// Combinational legality check of one routing-select word against the
// top/bottom and left/right wire counts.
module matrix_cfg_word_check
   import matrix_cfg_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   output logic              o_legal
);

   logic [SEL_W-1:0] w_sel;
   logic [IDX_W-1:0] w_idx;

   assign w_sel = i_word[SEL_W-1:0];
   assign w_idx = i_word[WORD_W-1:SEL_W];

   always_comb begin
      o_legal = 1'b0;
      case (w_sel)
         SIDE_NONE:              o_legal = 1'b1;
         SIDE_TOP, SIDE_BOTTOM:  o_legal = (int'(w_idx) < int'(NTB));
         SIDE_RIGHT, SIDE_LEFT:  o_legal = (int'(w_idx) < int'(NLR));
         default:                o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/matrix_cfg_loader.sv
// Serial frame loader: assembles 18 select words into a shadow register and
// commits them atomically to the config bus only after field and parity checks.
module matrix_cfg_loader
   import matrix_cfg_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cfg_start,
   input  logic             i_cfg_valid,
   input  logic             i_cfg_bit,
   output logic             o_cfg_busy,
   output logic             o_cfg_done,
   output logic             o_cfg_err,
   output logic [1:0]       o_cfg_err_code,
   output logic [CFG_W-1:0] o_cfg_out
);

   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);

   state_e              r_state,     w_state_d;
   logic [CFG_W-1:0]    r_shadow,    w_shadow_d;
   logic [CFG_W-1:0]    r_cfg_out,   w_cfg_out_d;
   logic [BIT_W-1:0]    r_bit_cnt,   w_bit_cnt_d;
   logic [WCNT_W-1:0]   r_word_cnt,  w_word_cnt_d;
   logic                r_field_err, w_field_err_d;
   logic                r_parity,    w_parity_d;
   logic                r_done,      w_done_d;
   logic                r_err,       w_err_d;
   logic [1:0]          r_err_code,  w_err_code_d;

   logic [POS_W-1:0]    w_base;
   logic [POS_W-1:0]    w_pos;
   logic [WORD_W-1:0]   w_word;
   logic                w_legal;
   logic [1:0]          w_code;

   assign w_base = bit_pos(r_word_cnt, '0);
   assign w_pos  = bit_pos(r_word_cnt, r_bit_cnt);
   // The word under check includes the bit being accepted this cycle
   assign w_word = {i_cfg_bit, r_shadow[w_base +: WORD_W-1]};
   assign w_code = {r_parity ^ i_cfg_bit, r_field_err};

   matrix_cfg_word_check u_word_check (
      .i_word  (w_word),
      .o_legal (w_legal)
   );

   always_comb begin
      w_state_d     = r_state;
      w_shadow_d    = r_shadow;
      w_cfg_out_d   = r_cfg_out;
      w_bit_cnt_d   = r_bit_cnt;
      w_word_cnt_d  = r_word_cnt;
      w_field_err_d = r_field_err;
      w_parity_d    = r_parity;
      w_done_d      = 1'b0;
      w_err_d       = 1'b0;
      w_err_code_d  = r_err_code;

      if (i_cfg_start) begin
         // Start wins in every state, including over a same-cycle data bit
         w_state_d     = StLoad;
         w_bit_cnt_d   = '0;
         w_word_cnt_d  = '0;
         w_field_err_d = 1'b0;
         w_parity_d    = 1'b0;
      end else if (i_cfg_valid) begin
         case (r_state)
            StLoad: begin
               w_shadow_d[w_pos] = i_cfg_bit;
               w_parity_d        = r_parity ^ i_cfg_bit;
               if (r_bit_cnt == LAST_BIT) begin
                  w_bit_cnt_d   = '0;
                  w_field_err_d = r_field_err | ~w_legal;
                  if (r_word_cnt == LAST_WORD) begin
                     w_state_d = StParity;
                  end else begin
                     w_word_cnt_d = r_word_cnt + 1'b1;
                  end
               end else begin
                  w_bit_cnt_d = r_bit_cnt + 1'b1;
               end
            end
            StParity: begin
               w_state_d    = StIdle;
               w_err_code_d = w_code;
               if (w_code == ERR_NONE) begin
                  w_cfg_out_d = r_shadow;
                  w_done_d    = 1'b1;
               end else begin
                  w_err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_shadow    <= '0;
         r_cfg_out   <= '0;
         r_bit_cnt   <= '0;
         r_word_cnt  <= '0;
         r_field_err <= 1'b0;
         r_parity    <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
      end else begin
         r_state     <= w_state_d;
         r_shadow    <= w_shadow_d;
         r_cfg_out   <= w_cfg_out_d;
         r_bit_cnt   <= w_bit_cnt_d;
         r_word_cnt  <= w_word_cnt_d;
         r_field_err <= w_field_err_d;
         r_parity    <= w_parity_d;
         r_done      <= w_done_d;
         r_err       <= w_err_d;
         r_err_code  <= w_err_code_d;
      end
   end

   assign o_cfg_busy     = (r_state != StIdle);
   assign o_cfg_done     = r_done;
   assign o_cfg_err      = r_err;
   assign o_cfg_err_code = r_err_code;
   assign o_cfg_out      = r_cfg_out;

endmodule

// File: tb/tb_matrix_cfg_loader.sv
// Directed bench for matrix_cfg_loader with a frame-result scoreboard.
module tb_matrix_cfg_loader;

   localparam int CFG_W = 108;

   typedef struct {
      logic             done;
      logic [1:0]       code;
      logic [CFG_W-1:0] out;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_start = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_bit = 1'b0;
   logic             cfg_busy;
   logic             cfg_done;
   logic             cfg_err;
   logic [1:0]       cfg_err_code;
   logic [CFG_W-1:0] cfg_out;

   int               total = 0;
   int               bad = 0;
   int               n_done = 0;
   exp_t             sb_q[$];
   logic [CFG_W-1:0] model_out = '0;

   matrix_cfg_loader dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_cfg_start    (cfg_start),
      .i_cfg_valid    (cfg_valid),
      .i_cfg_bit      (cfg_bit),
      .o_cfg_busy     (cfg_busy),
      .o_cfg_done     (cfg_done),
      .o_cfg_err      (cfg_err),
      .o_cfg_err_code (cfg_err_code),
      .o_cfg_out      (cfg_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic bit word_legal(input logic [5:0] w);
      logic [2:0] sel;
      logic [2:0] idx;
      sel = w[2:0];
      idx = w[5:3];
      if (sel == 3'd0) return 1'b1;
      if (sel == 3'd1 || sel == 3'd3) return idx <= 3'd4;
      if (sel == 3'd2 || sel == 3'd4) return idx <= 3'd3;
      return 1'b0;
   endfunction

   function automatic logic good_parity(input logic [CFG_W-1:0] d);
      logic p;
      p = 1'b0;
      for (int i = 0; i < CFG_W; i++) p = p ^ d[i];
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit stall);
      if (stall) begin
         repeat ($urandom_range(0, 3)) begin
            cfg_valid = 1'b0;
            tick();
         end
      end
      cfg_valid = 1'b1;
      cfg_bit   = b;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic send_frame(input string tag, input logic [CFG_W-1:0] d, input logic par,
                             input bit stall, input bit collide);
      bit   ill;
      logic pf;
      exp_t e;
      cfg_start = 1'b1;
      cfg_valid = collide;
      cfg_bit   = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      chk({tag, "_busy_load"}, cfg_busy, 1'b1);
      for (int i = 0; i < CFG_W; i++) send_bit(d[i], stall);
      ill = 1'b0;
      for (int w = 0; w < 18; w++) if (!word_legal(d[w*6 +: 6])) ill = 1'b1;
      pf = good_parity(d) ^ par;
      e.code = {pf, ill};
      e.done = (e.code == 2'b00);
      if (e.done) model_out = d;
      e.out = model_out;
      sb_q.push_back(e);
      send_bit(par, stall);
      @(negedge clk);
      chk({tag, "_done_lat"}, cfg_done, e.done);
      chk({tag, "_err_lat"}, cfg_err, !e.done);
      chk({tag, "_busy_end"}, cfg_busy, 1'b0);
   endtask

   // Scoreboard: every frame-end pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && (cfg_done || cfg_err)) begin
         total++;
         assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_pulse: got done=%0b err=%0b want none", cfg_done, cfg_err);
         end
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_done", cfg_done, e.done);
            chk("sb_code", cfg_err_code, e.code);
            chk("sb_out", cfg_out, e.out);
         end
         if (cfg_done) n_done++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [CFG_W-1:0] frm_a;
      logic [CFG_W-1:0] frm_b;
      logic [CFG_W-1:0] frm_f;
      logic [CFG_W-1:0] frm_s;
      int               d0;

      frm_a = '0;
      frm_a[5:0]     = 6'h1A;
      frm_a[107:102] = 6'h0C;
      frm_b = '0;
      frm_b[11:6]    = 6'h21;   // top1: sel 1, idx 4
      frm_b[71:66]   = 6'h14;   // left1: sel 4, idx 2
      frm_f = '0;
      frm_f[65:60]   = 6'h22;   // left0: sel 2, idx 4 -> illegal
      frm_s = '0;
      frm_s[47:42]   = 6'h06;   // bottom2: sel 6 -> illegal

      #3;
      chk("rst_busy", cfg_busy, 1'b0);
      chk("rst_done", cfg_done, 1'b0);
      chk("rst_err", cfg_err, 1'b0);
      chk("rst_code", cfg_err_code, 2'b00);
      chk("rst_out", cfg_out, '0);
      tick();
      rst = 1'b0;
      tick();

      send_frame("valid_a", frm_a, good_parity(frm_a), 1'b0, 1'b0);
      chk("valid_a_low", cfg_out[5:0], 6'h1A);
      chk("valid_a_high", cfg_out[107:102], 6'h0C);
      tick();
      chk("done_one_cycle", cfg_done, 1'b0);

      // Reset in the middle of a frame
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < 40; i++) send_bit(frm_b[i], 1'b0);
      rst = 1'b1;
      #2;
      chk("midrst_busy", cfg_busy, 1'b0);
      chk("midrst_out", cfg_out, '0);
      chk("midrst_done", cfg_done, 1'b0);
      chk("midrst_err", cfg_err, 1'b0);
      model_out = '0;
      tick();
      rst = 1'b0;
      tick();

      send_frame("clean_b", frm_b, good_parity(frm_b), 1'b0, 1'b0);
      send_frame("par_err", frm_a, ~good_parity(frm_a), 1'b0, 1'b0);
      send_frame("field_err", frm_f, good_parity(frm_f), 1'b0, 1'b0);
      send_frame("both_err", frm_s, ~good_parity(frm_s), 1'b0, 1'b0);
      tick();
      chk("code_hold", cfg_err_code, 2'b11);

      // Abort a frame at bit 70 with stalls, then a clean frame
      d0 = n_done;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int i = 0; i < 70; i++) send_bit(frm_b[i], 1'b1);
      send_frame("restart", frm_a, good_parity(frm_a), 1'b1, 1'b0);
      tick();
      chk("restart_one_done", n_done, d0 + 1);

      // Start and valid colliding: the colliding bit must be discarded
      send_frame("collide", frm_b, good_parity(frm_b), 1'b0, 1'b1);
      repeat (3) tick();
      chk("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
